// File: rtl/mapper_pkg.sv
// Shared types for the mapper I/O trap capture path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mapper_pkg;

    // Readout byte pointer; advances once per completed bus read.
    typedef enum logic [1:0] {
        BYTE_LO    = 2'd0,
        BYTE_HI    = 2'd1,
        BYTE_DATA  = 2'd2,
        BYTE_FLAGS = 2'd3
    } byte_ptr_e;

    // Bit positions inside the FLAGS record byte.
    localparam int FLG_VALID = 7;
    localparam int FLG_OVF   = 6;
    localparam int FLG_WR    = 0;

    // One trapped I/O cycle: full address, data seen, direction (25 bits).
    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
        logic        is_write;
    } cap_rec_t;

endpackage

// File: rtl/capture_fifo.sv
// Generic synchronous FIFO, DEPTH entries of WIDTH bits, power-of-two depth.
// Latency: push visible at the head one clock later; head is combinational from storage.
// Backpressure: push while full is dropped unless a pop lands on the same clock.
//
// Ports: clk/reset_n; push_vld + push_dat write; pop_vld removes head;
//        head_dat is the oldest entry; full/empty reflect registered count.
module capture_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_vld,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    // A pop frees a slot first, so a full FIFO still takes a same-clock push.
    assign do_pop  = pop_vld && !empty;
    assign do_push = push_vld && (!full || do_pop);

    assign head_dat = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: nothing is read while count is zero.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat;
    end

endmodule

// File: rtl/io_trap_capture.sv
// Records trapped Z80 I/O cycles and replays them as 4-byte records (LO, HI, DATA, FLAGS).
// Latency: capture edge at clock k -> stored k+1 -> trap_pending k+2; readout combinational.
// Backpressure: full FIFO drops new records and sets sticky overflow (cleared on a read FLAGS).
//
// Ports: capture_address/addr/data_in/wr_n describe the trapped cycle;
//        read_sel/rd_n read the capture port, ptr_clear rewinds the byte pointer;
//        data_out/data_oe drive the bus; trap_pending/overflow are status flags.
module io_trap_capture
    import mapper_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        capture_address,
    input  logic [15:0] addr,
    input  logic [7:0]  data_in,
    input  logic        wr_n,
    input  logic        read_sel,
    input  logic        rd_n,
    input  logic        ptr_clear,
    output logic [7:0]  data_out,
    output logic        data_oe,
    output logic        trap_pending,
    output logic        overflow
);

    logic      cap_q;
    logic      rd_q;
    logic      ovf_q,      ovf_d;
    logic      ovf_seen_q, ovf_seen_d;
    logic      pend_q;
    byte_ptr_e ptr_q,      ptr_d;

    logic      rd_act;
    logic      rd_end;
    logic      cap_edge;
    logic      leave_flags;
    logic      pop;
    logic      fifo_full;
    logic      fifo_empty;
    cap_rec_t  push_rec;
    cap_rec_t  head_rec;

    assign rd_act   = read_sel && !rd_n;
    assign rd_end   = rd_q && !rd_act;
    assign cap_edge = capture_address && !cap_q;

    always_comb begin
        push_rec          = '0;
        push_rec.addr     = addr;
        push_rec.is_write = !wr_n;
        push_rec.data     = !wr_n ? data_in : 8'hFF;
    end

    // ptr_clear outranks a same-clock advance, which also suppresses the pop.
    assign leave_flags = rd_end && !ptr_clear && (ptr_q == BYTE_FLAGS);
    assign pop         = leave_flags && !fifo_empty;

    capture_fifo #(
        .WIDTH ($bits(cap_rec_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push_vld (cap_edge),
        .push_dat (push_rec),
        .pop_vld  (pop),
        .head_dat (head_rec),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        ptr_d = ptr_q;
        if (ptr_clear) begin
            ptr_d = BYTE_LO;
        end else if (rd_end) begin
            case (ptr_q)
                BYTE_LO:   ptr_d = BYTE_HI;
                BYTE_HI:   ptr_d = BYTE_DATA;
                BYTE_DATA: ptr_d = BYTE_FLAGS;
                default:   ptr_d = BYTE_LO;
            endcase
        end
    end

    // Overflow clears only if the FLAGS byte the handler saw had it set;
    // sample it at the start of each strobe so a drop during the read is not lost.
    always_comb begin
        ovf_seen_d = ovf_seen_q;
        if (rd_act && !rd_q) ovf_seen_d = ovf_q;

        ovf_d = ovf_q;
        if (leave_flags && ovf_seen_q)   ovf_d = 1'b0;
        if (cap_edge && fifo_full && !pop) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_q      <= 1'b0;
            rd_q       <= 1'b0;
            ovf_q      <= 1'b0;
            ovf_seen_q <= 1'b0;
            pend_q     <= 1'b0;
            ptr_q      <= BYTE_LO;
        end else begin
            cap_q      <= capture_address;
            rd_q       <= rd_act;
            ovf_q      <= ovf_d;
            ovf_seen_q <= ovf_seen_d;
            pend_q     <= !fifo_empty;
            ptr_q      <= ptr_d;
        end
    end

    always_comb begin
        data_out = 8'h00;
        if (fifo_empty) begin
            if (ptr_q == BYTE_FLAGS) data_out[FLG_OVF] = ovf_q;
        end else begin
            case (ptr_q)
                BYTE_LO:   data_out = head_rec.addr[7:0];
                BYTE_HI:   data_out = head_rec.addr[15:8];
                BYTE_DATA: data_out = head_rec.data;
                default: begin
                    data_out[FLG_VALID] = 1'b1;
                    data_out[FLG_OVF]   = ovf_q;
                    data_out[FLG_WR]    = head_rec.is_write;
                end
            endcase
        end
    end

    assign data_oe      = rd_act;
    assign trap_pending = pend_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_io_trap_capture.sv
module tb_io_trap_capture;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        capture_address;
    logic [15:0] addr;
    logic [7:0]  data_in;
    logic        wr_n;
    logic        read_sel;
    logic        rd_n;
    logic        ptr_clear;
    logic [7:0]  data_out;
    logic        data_oe;
    logic        trap_pending;
    logic        overflow;

    int n_chk  = 0;
    int n_pass = 0;

    io_trap_capture #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .capture_address (capture_address),
        .addr            (addr),
        .data_in         (data_in),
        .wr_n            (wr_n),
        .read_sel        (read_sel),
        .rd_n            (rd_n),
        .ptr_clear       (ptr_clear),
        .data_out        (data_out),
        .data_oe         (data_oe),
        .trap_pending    (trap_pending),
        .overflow        (overflow)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_trap(input logic [15:0] a, input logic [7:0] d,
                           input logic is_wr, input int hold);
        addr            = a;
        data_in         = d;
        wr_n            = !is_wr;
        capture_address = 1'b1;
        cyc(hold);
        capture_address = 1'b0;
        wr_n            = 1'b1;
        cyc(1);
    endtask

    // One bus read of the capture port: strobe spans one rising edge, the
    // pointer advances on the following rising edge.
    task automatic bus_read(output logic [7:0] v);
        read_sel = 1'b1;
        rd_n     = 1'b0;
        cyc(1);
        v        = data_out;
        read_sel = 1'b0;
        rd_n     = 1'b1;
        cyc(1);
    endtask

    task automatic test_reset;
        reset_n = 1'b0; capture_address = 1'b0; addr = '0; data_in = '0;
        wr_n = 1'b1; read_sel = 1'b0; rd_n = 1'b1; ptr_clear = 1'b0;
        cyc(3);
        n_chk++; if (trap_pending !== 1'b0) $display("FAIL reset_pending: got %b want 0", trap_pending); else n_pass++;
        n_chk++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow); else n_pass++;
        n_chk++; if (data_out !== 8'h00) $display("FAIL reset_data_out: got %h want 00", data_out); else n_pass++;
        n_chk++; if (data_oe !== 1'b0) $display("FAIL reset_data_oe: got %b want 0", data_oe); else n_pass++;
        reset_n = 1'b1;
        cyc(2);
    endtask

    task automatic test_single_trap;
        logic [7:0] v;
        logic [7:0] exp [4];
        exp = '{8'hA5, 8'h12, 8'h3C, 8'h81};
        addr = 16'h12A5; data_in = 8'h3C; wr_n = 1'b0; capture_address = 1'b1;
        cyc(1);
        n_chk++; if (trap_pending !== 1'b0) $display("FAIL single_pending_k1: got %b want 0", trap_pending); else n_pass++;
        capture_address = 1'b0; wr_n = 1'b1;
        cyc(1);
        n_chk++; if (trap_pending !== 1'b1) $display("FAIL single_pending_k2: got %b want 1", trap_pending); else n_pass++;
        read_sel = 1'b1; rd_n = 1'b0;
        #1;
        n_chk++; if (data_oe !== 1'b1) $display("FAIL single_data_oe: got %b want 1", data_oe); else n_pass++;
        read_sel = 1'b0; rd_n = 1'b1;
        #1;
        n_chk++; if (data_oe !== 1'b0) $display("FAIL single_data_oe_off: got %b want 0", data_oe); else n_pass++;
        cyc(1);
        for (int i = 0; i < 4; i++) begin
            bus_read(v);
            n_chk++; if (v !== exp[i]) $display("FAIL single_byte%0d: got %h want %h", i, v, exp[i]); else n_pass++;
        end
        n_chk++; if (trap_pending !== 1'b1) $display("FAIL single_pending_pop: got %b want 1", trap_pending); else n_pass++;
        cyc(1);
        n_chk++; if (trap_pending !== 1'b0) $display("FAIL single_pending_drop: got %b want 0", trap_pending); else n_pass++;
    endtask

    task automatic test_read_trap;
        logic [7:0] v;
        logic [7:0] exp [4];
        exp = '{8'h40, 8'h00, 8'hFF, 8'h80};
        do_trap(16'h0040, 8'h5A, 1'b0, 1);
        for (int i = 0; i < 4; i++) begin
            bus_read(v);
            n_chk++; if (v !== exp[i]) $display("FAIL read_trap_byte%0d: got %h want %h", i, v, exp[i]); else n_pass++;
        end
    endtask

    task automatic test_long_capture;
        logic [7:0] v;
        logic [7:0] exp [8];
        exp = '{8'h77, 8'h00, 8'h55, 8'h81, 8'h00, 8'h00, 8'h00, 8'h00};
        do_trap(16'h0077, 8'h55, 1'b1, 5);
        for (int i = 0; i < 8; i++) begin
            bus_read(v);
            n_chk++; if (v !== exp[i]) $display("FAIL long_capture_byte%0d: got %h want %h", i, v, exp[i]); else n_pass++;
        end
    endtask

    task automatic test_overflow;
        logic [7:0] v;
        logic [7:0] exp [4];
        for (int p = 1; p <= DEPTH + 1; p++) do_trap(16'(p), 8'h00, 1'b0, 1);
        n_chk++; if (overflow !== 1'b1) $display("FAIL ovf_set: got %b want 1", overflow); else n_pass++;
        exp = '{8'h01, 8'h00, 8'hFF, 8'hC0};
        for (int i = 0; i < 4; i++) begin
            bus_read(v);
            n_chk++; if (v !== exp[i]) $display("FAIL ovf_rec1_byte%0d: got %h want %h", i, v, exp[i]); else n_pass++;
        end
        n_chk++; if (overflow !== 1'b0) $display("FAIL ovf_cleared: got %b want 0", overflow); else n_pass++;
        for (int r = 2; r <= DEPTH; r++) begin
            exp = '{8'(r), 8'h00, 8'hFF, 8'h80};
            for (int i = 0; i < 4; i++) begin
                bus_read(v);
                n_chk++; if (v !== exp[i]) $display("FAIL ovf_rec%0d_byte%0d: got %h want %h", r, i, v, exp[i]); else n_pass++;
            end
        end
        for (int i = 0; i < 4; i++) begin
            bus_read(v);
            n_chk++; if (v !== 8'h00) $display("FAIL ovf_empty_byte%0d: got %h want 00", i, v); else n_pass++;
        end
        n_chk++; if (trap_pending !== 1'b0) $display("FAIL ovf_drained: got %b want 0", trap_pending); else n_pass++;
    endtask

    task automatic test_pop_push_same_clock;
        logic [7:0] v;
        for (int p = 0; p < DEPTH; p++) do_trap(16'h0011 + 16'(p), 8'h00, 1'b0, 1);
        for (int i = 0; i < 3; i++) bus_read(v);
        read_sel = 1'b1; rd_n = 1'b0;
        cyc(1);
        n_chk++; if (data_out !== 8'h80) $display("FAIL popush_flags: got %h want 80", data_out); else n_pass++;
        read_sel = 1'b0; rd_n = 1'b1;
        addr = 16'h0015; wr_n = 1'b1; capture_address = 1'b1;
        cyc(1);
        capture_address = 1'b0;
        cyc(1);
        n_chk++; if (overflow !== 1'b0) $display("FAIL popush_overflow: got %b want 0", overflow); else n_pass++;
        for (int r = 0; r < DEPTH; r++) begin
            bus_read(v);
            n_chk++; if (v !== 8'h12 + 8'(r)) $display("FAIL popush_rec%0d_lo: got %h want %h", r, v, 8'h12 + 8'(r)); else n_pass++;
            bus_read(v);
            bus_read(v);
            bus_read(v);
            n_chk++; if (v !== 8'h80) $display("FAIL popush_rec%0d_flags: got %h want 80", r, v); else n_pass++;
        end
        cyc(1);
        n_chk++; if (trap_pending !== 1'b0) $display("FAIL popush_drained: got %b want 0", trap_pending); else n_pass++;
    endtask

    task automatic test_ptr_clear_and_reset;
        logic [7:0] v;
        do_trap(16'h3456, 8'h9A, 1'b1, 1);
        bus_read(v);
        n_chk++; if (v !== 8'h56) $display("FAIL clr_lo: got %h want 56", v); else n_pass++;
        bus_read(v);
        n_chk++; if (v !== 8'h34) $display("FAIL clr_hi: got %h want 34", v); else n_pass++;
        ptr_clear = 1'b1;
        cyc(1);
        ptr_clear = 1'b0;
        bus_read(v);
        n_chk++; if (v !== 8'h56) $display("FAIL clr_lo_again: got %h want 56", v); else n_pass++;
        n_chk++; if (trap_pending !== 1'b1) $display("FAIL clr_no_pop: got %b want 1", trap_pending); else n_pass++;
        bus_read(v);
        reset_n = 1'b0;
        cyc(1);
        n_chk++; if (trap_pending !== 1'b0) $display("FAIL midrec_reset_pending: got %b want 0", trap_pending); else n_pass++;
        n_chk++; if (data_out !== 8'h00) $display("FAIL midrec_reset_data: got %h want 00", data_out); else n_pass++;
        reset_n = 1'b1;
        cyc(1);
        do_trap(16'h0102, 8'h00, 1'b0, 1);
        bus_read(v);
        n_chk++; if (v !== 8'h02) $display("FAIL midrec_reset_lo: got %h want 02", v); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_trap();
        test_read_trap();
        test_long_capture();
        test_overflow();
        test_pop_push_same_clock();
        test_ptr_clear_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
